hazard_scoreboard: RTL

Parametrised successor to the ID-stage hazard unit. It replaces the fixed single-cycle load-use compare with a per-register pending-latency scoreboard. It stalls on RAW and WAW hazards for producers of any latency up to 2**LAT_W-1, and sequences multi-op (mop) instructions with a down-counter instead of a combinational OR of stage flags. It sits beside the ID stage, observes the instruction leaving ID, and drives stall/flush to the pipeline registers.

---
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register pending-latency scoreboard with mop sequencer
// Optional event counters are built when HAZARD_STAT_EN is defined.
module hazard_scoreboard #(
  parameter int REG_W = 6,
  parameter int LAT_W = 3,
  parameter int MOP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_we,
  input  logic [LAT_W-1:0] id_lat,
  input  logic [MOP_W-1:0] id_mop_len,
  input  logic             br_ctrl,
  output logic             raw_stall,
  output logic             waw_stall,
  output logic             mop_stall,
  output logic             stall,
  output logic             flush,
  output logic             issue,
  output logic [31:0]      stat_load,
  output logic [31:0]      stat_mop,
  output logic [31:0]      stat_flush
);

  localparam int NREG = 1 << REG_W;

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [MOP_W-1:0] mop_cnt_q, mop_cnt_d;
  logic             rs1_hit, rs2_hit, rd_track;

  // x0 is hardwired, so it never participates in a hazard.
  assign rs1_hit  = id_rs1_used && (id_rs1 != '0) && (cnt_q[id_rs1] != '0);
  assign rs2_hit  = id_rs2_used && (id_rs2 != '0) && (cnt_q[id_rs2] != '0);
  assign rd_track = id_rd_we && (id_rd != '0);

  assign raw_stall = id_valid && (rs1_hit || rs2_hit);
  assign waw_stall = id_valid && rd_track && (cnt_q[id_rd] > id_lat);
  assign mop_stall = (mop_cnt_q != '0);
  assign stall     = raw_stall || waw_stall || mop_stall;
  assign flush     = br_ctrl;
  assign issue     = id_valid && !stall && !br_ctrl;

  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      if (issue && rd_track && (id_rd == REG_W'(r))) begin
        cnt_d[r] = id_lat;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end
  end

  always_comb begin
    mop_cnt_d = mop_cnt_q;
    if (issue && (id_mop_len != '0)) begin
      mop_cnt_d = id_mop_len;
    end else if (mop_cnt_q != '0) begin
      mop_cnt_d = mop_cnt_q - MOP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      mop_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      mop_cnt_q <= mop_cnt_d;
    end
  end

`ifdef HAZARD_STAT_EN
  logic [31:0] stat_load_q, stat_load_d;
  logic [31:0] stat_mop_q, stat_mop_d;
  logic [31:0] stat_flush_q, stat_flush_d;

  always_comb begin
    stat_load_d  = stat_load_q + (raw_stall ? 32'd1 : 32'd0);
    stat_mop_d   = stat_mop_q + (mop_stall ? 32'd1 : 32'd0);
    stat_flush_d = stat_flush_q + (br_ctrl ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_load_q  <= '0;
      stat_mop_q   <= '0;
      stat_flush_q <= '0;
    end else begin
      stat_load_q  <= stat_load_d;
      stat_mop_q   <= stat_mop_d;
      stat_flush_q <= stat_flush_d;
    end
  end

  assign stat_load  = stat_load_q;
  assign stat_mop   = stat_mop_q;
  assign stat_flush = stat_flush_q;
`else
  assign stat_load  = 32'd0;
  assign stat_mop   = 32'd0;
  assign stat_flush = 32'd0;
`endif

endmodule
